// File: rtl/dice_pkg.sv
// Shared types and constants for the dice display path: FSM states, scan phases,
// and single-segment masks in {g,f,e,d,c,b,a} order.
package dice_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SPIN  = 2'd1,
      BLINK = 2'd2
   } state_t;

   localparam logic [1:0] PH_BLANK0 = 2'd0;
   localparam logic [1:0] PH_UNITS  = 2'd1;
   localparam logic [1:0] PH_BLANK1 = 2'd2;
   localparam logic [1:0] PH_TENS   = 2'd3;

   localparam logic [6:0] SEG_A   = 7'h01;
   localparam logic [6:0] SEG_B   = 7'h02;
   localparam logic [6:0] SEG_C   = 7'h04;
   localparam logic [6:0] SEG_D   = 7'h08;
   localparam logic [6:0] SEG_E   = 7'h10;
   localparam logic [6:0] SEG_F   = 7'h20;
   localparam logic [6:0] SEG_G   = 7'h40;
   localparam logic [6:0] SEG_OFF = 7'h00;

   // Chase position 0..5 walks the outer ring a..f; anything else is dark.
   function automatic logic [6:0] chase_seg(input logic [2:0] idx);
      case (idx)
         3'd0:    chase_seg = SEG_A;
         3'd1:    chase_seg = SEG_B;
         3'd2:    chase_seg = SEG_C;
         3'd3:    chase_seg = SEG_D;
         3'd4:    chase_seg = SEG_E;
         3'd5:    chase_seg = SEG_F;
         default: chase_seg = SEG_OFF;
      endcase
   endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder, active-high, {g,f,e,d,c,b,a}.
// Non-decimal codes 10-15 decode to a dark digit.
module bcd_to_seg7
   import dice_pkg::*;
(
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_OFF;
      case (i_bcd)
         4'd0: o_seg = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F;
         4'd1: o_seg = SEG_B | SEG_C;
         4'd2: o_seg = SEG_A | SEG_B | SEG_D | SEG_E | SEG_G;
         4'd3: o_seg = SEG_A | SEG_B | SEG_C | SEG_D | SEG_G;
         4'd4: o_seg = SEG_B | SEG_C | SEG_F | SEG_G;
         4'd5: o_seg = SEG_A | SEG_C | SEG_D | SEG_F | SEG_G;
         4'd6: o_seg = SEG_A | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
         4'd7: o_seg = SEG_A | SEG_B | SEG_C;
         4'd8: o_seg = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
         4'd9: o_seg = SEG_A | SEG_B | SEG_C | SEG_D | SEG_F | SEG_G;
         default: o_seg = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/dice_display_driver.sv
// Two-digit multiplexed seven-segment driver for the dice: chase animation while
// rolling, result blink after release, blanked scan slots between digit selects.
module dice_display_driver
   import dice_pkg::*;
#(
   parameter int BLINK_TICKS = 8,
   parameter int BLINK_COUNT = 3,
   parameter int SPIN_TICKS  = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       rolling,
   input  logic [3:0] digit1,
   input  logic [3:0] digit10,
   input  logic       seg_inv,
   input  logic       com_inv,
   output logic [7:0] seg_out,
   output logic [1:0] com_out,
   output logic       busy
);

   localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam int PW = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT + 1) : 1;
   localparam int SW = (SPIN_TICKS > 1) ? $clog2(SPIN_TICKS) : 1;
   localparam logic [BW-1:0] BT_LAST = BW'(BLINK_TICKS - 1);
   localparam logic [PW-1:0] PC_LAST = PW'(BLINK_COUNT - 1);
   localparam logic [SW-1:0] ST_LAST = SW'(SPIN_TICKS - 1);

   state_t          r_state;
   logic [1:0]      r_phase;
   logic [3:0]      r_d1;
   logic [3:0]      r_d10;
   logic [2:0]      r_ci;
   logic [SW-1:0]   r_spin_cnt;
   logic [BW-1:0]   r_blink_cnt;
   logic [PW-1:0]   r_pair_cnt;
   logic            r_blink_on;
   logic [7:0]      r_seg_log;
   logic [1:0]      r_com_log;
   logic            r_busy;

   logic [3:0]      w_sel_digit;
   logic [6:0]      w_dec_seg;
   logic [2:0]      w_ci_tens;
   logic [6:0]      w_glyph;
   logic            w_dark;
   logic            w_tens_blank;
   logic [7:0]      w_seg_nxt;
   logic [1:0]      w_com_nxt;

   assign w_sel_digit = (r_phase == PH_TENS) ? r_d10 : r_d1;

   bcd_to_seg7 u_dec (
      .i_bcd (w_sel_digit),
      .o_seg (w_dec_seg)
   );

   // Tens chases half a lap ahead of units: (ci + 3) mod 6.
   assign w_ci_tens    = (r_ci < 3'd3) ? (r_ci + 3'd3) : (r_ci - 3'd3);
   assign w_glyph      = (r_state != SPIN) ? w_dec_seg :
                         (r_phase == PH_TENS) ? chase_seg(w_ci_tens) : chase_seg(r_ci);
   assign w_dark       = (r_state == BLINK) && !r_blink_on;
   assign w_tens_blank = (r_state != SPIN) && (r_d10 == 4'd0);

   always_comb begin
      w_seg_nxt = 8'h00;
      w_com_nxt = 2'b00;
      case (r_phase)
         PH_UNITS: begin
            w_seg_nxt = {1'b0, w_glyph};
            w_com_nxt = w_dark ? 2'b00 : 2'b01;
         end
         PH_TENS: begin
            w_seg_nxt = {1'b0, w_glyph};
            w_com_nxt = (w_dark || w_tens_blank) ? 2'b00 : 2'b10;
         end
         default: begin
            w_seg_nxt = 8'h00;
            w_com_nxt = 2'b00;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase   <= PH_BLANK0;
         r_seg_log <= 8'h00;
         r_com_log <= 2'b00;
      end else begin
         r_phase   <= r_phase + 2'd1;
         r_seg_log <= w_seg_nxt;
         r_com_log <= w_com_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_d1        <= 4'd1;
         r_d10       <= 4'd0;
         r_ci        <= 3'd0;
         r_spin_cnt  <= '0;
         r_blink_cnt <= '0;
         r_pair_cnt  <= '0;
         r_blink_on  <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_busy <= (r_state != IDLE);
         case (r_state)
            IDLE: begin
               r_d1  <= digit1;
               r_d10 <= digit10;
               if (rolling) begin
                  r_state    <= SPIN;
                  r_ci       <= 3'd0;
                  r_spin_cnt <= '0;
               end
            end
            SPIN: begin
               if (!rolling) begin
                  r_state     <= BLINK;
                  r_d1        <= digit1;
                  r_d10       <= digit10;
                  r_blink_cnt <= '0;
                  r_pair_cnt  <= '0;
                  r_blink_on  <= 1'b0;
               end else if (tick) begin
                  if (r_spin_cnt == ST_LAST) begin
                     r_spin_cnt <= '0;
                     r_ci       <= (r_ci == 3'd5) ? 3'd0 : (r_ci + 3'd1);
                  end else begin
                     r_spin_cnt <= r_spin_cnt + 1'b1;
                  end
               end
            end
            BLINK: begin
               // A re-roll restarts the chase; the interrupted blink is discarded.
               if (rolling) begin
                  r_state     <= SPIN;
                  r_ci        <= 3'd0;
                  r_spin_cnt  <= '0;
                  r_blink_cnt <= '0;
                  r_pair_cnt  <= '0;
                  r_blink_on  <= 1'b0;
               end else if (tick) begin
                  if (r_blink_cnt == BT_LAST) begin
                     r_blink_cnt <= '0;
                     r_blink_on  <= ~r_blink_on;
                     if (r_blink_on) begin
                        if (r_pair_cnt == PC_LAST) r_state <= IDLE;
                        else r_pair_cnt <= r_pair_cnt + 1'b1;
                     end
                  end else begin
                     r_blink_cnt <= r_blink_cnt + 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign seg_out = r_seg_log ^ {8{seg_inv}};
   assign com_out = r_com_log ^ {2{com_inv}};
   assign busy    = r_busy;

endmodule

// File: tb/tb_dice_display_driver.sv
// Directed bench for dice_display_driver: static display, inversion, chase,
// blink timing, re-roll during blink and asynchronous reset.
module tb_dice_display_driver;

   localparam int TICK_GAP = 16;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic       tick    = 1'b0;
   logic       rolling = 1'b0;
   logic [3:0] digit1  = 4'd4;
   logic [3:0] digit10 = 4'd0;
   logic       seg_inv = 1'b0;
   logic       com_inv = 1'b0;
   logic [7:0] seg_out;
   logic [1:0] com_out;
   logic       busy;

   int n_vec = 0;
   int n_bad = 0;
   int cyc;

   logic [7:0] obs_seg [4];
   logic [1:0] obs_com [4];
   logic       obs_busy;

   dice_display_driver #(
      .BLINK_TICKS (8),
      .BLINK_COUNT (3),
      .SPIN_TICKS  (2)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick    (tick),
      .rolling (rolling),
      .digit1  (digit1),
      .digit10 (digit10),
      .seg_inv (seg_inv),
      .com_inv (com_inv),
      .seg_out (seg_out),
      .com_out (com_out),
      .busy    (busy)
   );

   // Clock and a reference scan-slot counter: after posedge k the pins show slot (k-1) mod 4.
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not complete, got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      int s;
      @(posedge clk);
      #1;
      s = (cyc + 3) % 4;
      obs_seg[s] = seg_out;
      obs_com[s] = com_out;
      obs_busy   = busy;
   endtask

   task automatic period(input bit do_tick);
      tick = do_tick;
      step();
      tick = 1'b0;
      repeat (TICK_GAP - 1) step();
   endtask

   function automatic logic [7:0] chase(input int n_ticks, input int offset);
      int k;
      k = ((n_ticks / 2) + offset) % 6;
      return 8'(1 << k);
   endfunction

   initial begin
      int on;

      // Reset with plain polarity.
      repeat (2) @(posedge clk);
      #1;
      check("rst_seg", seg_out, 8'h00);
      check("rst_com", com_out, 2'b00);
      check("rst_busy", busy, 1'b0);
      rst_n = 1'b1;

      // "04": tens zero is blanked, units shows 4.
      period(1'b0);
      check("s04_units_com", obs_com[1], 2'b01);
      check("s04_units_seg", obs_seg[1], 8'h66);
      check("s04_tens_com", obs_com[3], 2'b00);
      check("s04_blank0_seg", obs_seg[0], 8'h00);
      check("s04_blank0_com", obs_com[0], 2'b00);
      check("s04_blank1_seg", obs_seg[2], 8'h00);
      check("s04_busy", obs_busy, 1'b0);

      // "20" with both pin groups inverted.
      digit10 = 4'd2; digit1 = 4'd0; seg_inv = 1'b1; com_inv = 1'b1;
      period(1'b0);
      check("s20_tens_com", obs_com[3], 2'b01);
      check("s20_tens_seg", obs_seg[3], 8'hA4);
      check("s20_units_com", obs_com[1], 2'b10);
      check("s20_units_seg", obs_seg[1], 8'hC0);
      check("s20_blank_seg", obs_seg[0], 8'hFF);
      check("s20_blank_com", obs_com[2], 2'b11);
      seg_inv = 1'b0; com_inv = 1'b0;
      digit10 = 4'd0; digit1 = 4'd5;
      period(1'b0);

      // Chase for 12 ticks; tens is not zero-blanked while spinning.
      rolling = 1'b1;
      step();
      period(1'b0);
      check("spin_busy", obs_busy, 1'b1);
      check("spin_units_com", obs_com[1], 2'b01);
      check("spin_tens_com", obs_com[3], 2'b10);
      check("spin_u0", obs_seg[1], 8'h01);
      check("spin_t0", obs_seg[3], 8'h08);
      for (int n = 1; n <= 12; n++) begin
         period(1'b1);
         check($sformatf("spin_u%0d", n), obs_seg[1], chase(n, 0));
         check($sformatf("spin_t%0d", n), obs_seg[3], chase(n, 3));
      end

      // Release on "17": three off/on pairs of 8 ticks, then idle.
      digit10 = 4'd1; digit1 = 4'd7;
      rolling = 1'b0;
      step();
      digit10 = 4'd9; digit1 = 4'd9;
      period(1'b0);
      check("blk0_units_com", obs_com[1], 2'b00);
      check("blk0_tens_com", obs_com[3], 2'b00);
      check("blk0_busy", obs_busy, 1'b1);
      for (int n = 1; n < 48; n++) begin
         period(1'b1);
         on = (n / 8) % 2;
         check($sformatf("blk%0d_units_com", n), obs_com[1], (on != 0) ? 2'b01 : 2'b00);
         check($sformatf("blk%0d_tens_com", n), obs_com[3], (on != 0) ? 2'b10 : 2'b00);
         check($sformatf("blk%0d_busy", n), obs_busy, 1'b1);
         if (on != 0) check($sformatf("blk%0d_units_seg", n), obs_seg[1], 8'h07);
      end
      digit10 = 4'd1; digit1 = 4'd7;
      period(1'b1);
      check("end_busy", obs_busy, 1'b0);
      check("end_units_com", obs_com[1], 2'b01);
      check("end_units_seg", obs_seg[1], 8'h07);
      check("end_tens_com", obs_com[3], 2'b10);
      check("end_tens_seg", obs_seg[3], 8'h06);

      // Re-roll at tick 20 of a blink, with a tick in the same cycle.
      rolling = 1'b1;
      step();
      repeat (3) period(1'b1);
      rolling = 1'b0;
      step();
      repeat (20) period(1'b1);
      check("rr_blink_off", obs_com[1], 2'b00);
      rolling = 1'b1;
      tick = 1'b1;
      step();
      tick = 1'b0;
      period(1'b0);
      check("rr_units_com", obs_com[1], 2'b01);
      check("rr_ci0_units", obs_seg[1], 8'h01);
      check("rr_ci0_tens", obs_seg[3], 8'h08);
      repeat (3) period(1'b1);
      check("rr_ci1_units", obs_seg[1], 8'h02);
      rolling = 1'b0;
      step();
      period(1'b0);
      check("rb0_units_com", obs_com[1], 2'b00);
      for (int n = 1; n <= 48; n++) begin
         period(1'b1);
         if (n == 8)  check("rb8_units_com", obs_com[1], 2'b01);
         if (n == 16) check("rb16_units_com", obs_com[1], 2'b00);
         if (n == 47) check("rb47_busy", obs_busy, 1'b1);
         if (n == 48) check("rb48_busy", obs_busy, 1'b0);
      end

      // Reset in the middle of a blink.
      rolling = 1'b1;
      step();
      period(1'b1);
      digit10 = 4'd0; digit1 = 4'd1;
      rolling = 1'b0;
      step();
      repeat (10) period(1'b1);
      com_inv = 1'b1;
      step();
      rst_n = 1'b0;
      #1;
      check("mrst_seg", seg_out, 8'h00);
      check("mrst_com", com_out, 2'b11);
      check("mrst_busy", busy, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      period(1'b0);
      check("post_busy", obs_busy, 1'b0);
      check("post_units_com", obs_com[1], 2'b10);
      check("post_units_seg", obs_seg[1], 8'h06);
      check("post_tens_com", obs_com[3], 2'b11);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
